// File: rtl/mmio_interval_timer_pkg.sv
// Shared constants for the memory-mapped interval timer: register map,
// CTRL bit positions, bus region decode and FSM state encoding.
package mmio_interval_timer_pkg;

    localparam logic [1:0] REG_LOAD   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_AUTO = 1;

    localparam logic [1:0] TIMER_REGION = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mmio_interval_timer_tick_gen.sv
// Prescaler: free-runs 0..PRESCALE-1 while enabled and flags the terminal
// count as a one-cycle tick; restart or disable forces it back to 0.
module tick_gen #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (!enable || restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && !restart && (cnt_q == LAST);

endmodule

// File: rtl/mmio_interval_timer.sv
// Interval timer in bus region Addr[8:7]=2'b11: LOAD/CTRL/COUNT/STATUS
// registers, run/expiry FSM and a registered read port with 1-cycle latency.
module mmio_interval_timer
    import mmio_interval_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned N        = 9
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [8:0]   Addr,
    input  logic [N-1:0] Data,
    input  logic         W,
    output logic [N-1:0] Q,
    output logic         Tick,
    output logic         Expired
);

    state_e        state_q;
    logic [N-1:0]  load_q, count_q, q_q, rdata_d;
    logic          en_q, auto_q, expired_q;
    logic          sel, wr, wr_load, wr_ctrl, wr_count, wr_status;
    logic          tick, expire;
    logic          unused_addr;

    assign sel       = (Addr[8:7] == TIMER_REGION);
    assign wr        = W && sel;
    assign wr_load   = wr && (Addr[1:0] == REG_LOAD);
    assign wr_ctrl   = wr && (Addr[1:0] == REG_CTRL);
    assign wr_count  = wr && (Addr[1:0] == REG_COUNT);
    assign wr_status = wr && (Addr[1:0] == REG_STATUS);
    assign unused_addr = ^Addr[6:2];

    // Any CTRL write realigns the prescaler, so a start always gets a full first period.
    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .Clock   (Clock),
        .Reset   (Reset),
        .enable  (state_q == ST_RUN),
        .restart (wr_ctrl),
        .tick    (tick)
    );

    // A same-cycle COUNT or CTRL write overrides the tick; reset suppresses it.
    assign expire = tick && (count_q == '0) && !wr_count && !wr_ctrl && !Reset;

    always_comb begin
        rdata_d = '0;
        if (sel) begin
            case (Addr[1:0])
                REG_LOAD:   rdata_d = load_q;
                REG_CTRL:   rdata_d = {{(N-2){1'b0}}, auto_q, en_q};
                REG_COUNT:  rdata_d = count_q;
                default:    rdata_d = {{(N-1){1'b0}}, expired_q};
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            load_q    <= '0;
            count_q   <= '0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            expired_q <= 1'b0;
            q_q       <= '0;
        end else begin
            q_q <= rdata_d;
            if (wr_load) begin
                load_q <= Data;
            end
            if (wr_status && Data[0]) begin
                expired_q <= 1'b0;
            end
            if (expire) begin
                expired_q <= 1'b1;
            end
            if (wr_ctrl) begin
                en_q   <= Data[CTRL_EN];
                auto_q <= Data[CTRL_AUTO];
                if (Data[CTRL_EN]) begin
                    count_q <= load_q;
                    state_q <= ST_RUN;
                end else begin
                    state_q <= ST_IDLE;
                end
            end else if (wr_count) begin
                count_q <= Data;
            end else if (tick) begin
                if (count_q != '0) begin
                    count_q <= count_q - N'(1);
                end else if (auto_q) begin
                    count_q <= load_q;
                end else begin
                    en_q    <= 1'b0;
                    state_q <= ST_DONE;
                end
            end
        end
    end

    assign Q       = q_q;
    assign Tick    = expire;
    assign Expired = expired_q;

endmodule

// File: tb/tb_mmio_interval_timer.sv
// Directed bench for mmio_interval_timer with PRESCALE=4; reads are checked
// by a scoreboard monitor, Tick edges are timestamped by a cycle counter.
module tb_mmio_interval_timer;

    localparam int unsigned P = 4;

    logic       Clock = 1'b0;
    logic       Reset, W;
    logic [8:0] Addr, Data, Q;
    logic       Tick, Expired;

    mmio_interval_timer #(.PRESCALE(P), .N(9)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Addr    (Addr),
        .Data    (Data),
        .W       (W),
        .Q       (Q),
        .Tick    (Tick),
        .Expired (Expired)
    );

    always #5 Clock = ~Clock;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        rd_issued = 1'b0;
    logic        rd_valid = 1'b0;
    logic [8:0]  exp_q[$];
    string       name_q[$];
    int unsigned tick_log[$];

    always @(posedge Clock) begin
        cyc      <= cyc + 1;
        rd_valid <= rd_issued;
    end

    // Monitor: Q for a read issued in cycle k is compared in cycle k+1.
    always @(negedge Clock) begin : monitor
        logic [8:0] e;
        string      nm;
        if (Tick) tick_log.push_back(cyc);
        if (rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: Q=%0h with no expected value queued", Q);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (Q !== e) begin
                    n_fail++;
                    $display("FAIL %s: Q=%0h expected %0h (cycle %0d)", nm, Q, e, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input string nm, input int unsigned t);
        chk(nm, (cyc <= t), 1);
        while (cyc < t) step();
    endtask

    task automatic wr(input logic [8:0] a, input logic [8:0] d);
        Addr = a;
        Data = d;
        W    = 1'b1;
        step();
        W    = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [8:0] a, input logic [8:0] e);
        Addr = a;
        W    = 1'b0;
        exp_q.push_back(e);
        name_q.push_back(nm);
        rd_issued = 1'b1;
        step();
        rd_issued = 1'b0;
    endtask

    initial begin : stim
        int unsigned n, m, p, k;
        Reset = 1'b1;
        W     = 1'b0;
        Addr  = '0;
        Data  = '0;

        // 1: reset state
        repeat (2) step();
        Reset = 1'b0;
        chk("rst_tick", Tick, 0);
        chk("rst_expired", Expired, 0);
        rd("rst_load",   9'h180, 9'd0);
        rd("rst_ctrl",   9'h181, 9'd0);
        rd("rst_count",  9'h182, 9'd0);
        rd("rst_status", 9'h183, 9'd0);

        // 2: one-shot, LOAD=3 -> Tick at n+16
        wr(9'h180, 9'd3);
        tick_log.delete();
        n = cyc;
        wr(9'h181, 9'd1);
        repeat (20) begin
            k = (cyc - n - 1) / P;
            rd("t2_count", 9'h182, (k < 3) ? 9'(3 - k) : 9'd0);
        end
        chk("t2_tick_num", tick_log.size(), 1);
        chk("t2_tick_cyc", tick_log[0], n + 16);
        chk("t2_expired", Expired, 1);
        rd("t2_ctrl_done", 9'h181, 9'd0);
        rd("t2_status", 9'h183, 9'd1);

        // 3: auto-reload, LOAD=1 -> Tick every 8 cycles
        wr(9'h180, 9'd1);
        tick_log.delete();
        m = cyc;
        wr(9'h181, 9'd3);
        repeat (25) begin
            rd("t3_count", 9'h182, (((cyc - m - 1) % 8) < 4) ? 9'd1 : 9'd0);
        end
        chk("t3_tick_num", tick_log.size(), 3);
        chk("t3_tick0", tick_log[0], m + 8);
        chk("t3_tick1", tick_log[1], m + 16);
        chk("t3_tick2", tick_log[2], m + 24);
        chk("t3_expired", Expired, 1);
        rd("t3_ctrl", 9'h181, 9'd3);

        // 4: STATUS clear coinciding with expiry, then one cycle after
        tick_log.delete();
        wait_until("t4_sched_a", m + 32);
        wr(9'h183, 9'd1);
        chk("t4_clear_vs_expiry", Expired, 1);
        wait_until("t4_sched_b", m + 41);
        wr(9'h183, 9'd1);
        chk("t4_clear", Expired, 0);
        rd("t4_status", 9'h183, 9'd0);
        chk("t4_tick_num", tick_log.size(), 2);
        chk("t4_tick0", tick_log[0], m + 32);
        chk("t4_tick1", tick_log[1], m + 40);
        wr(9'h181, 9'd0);

        // 5: decode, latency and out-of-region accesses
        wr(9'h180, 9'd5);
        wr(9'h182, 9'd7);
        rd("t5_count", 9'h182, 9'd7);
        rd("t5_led_region", 9'h080, 9'd0);
        wr(9'h000, 9'h1FF);
        wr(9'h002, 9'h1AA);
        wr(9'h001, 9'd3);
        rd("t5_load_kept", 9'h180, 9'd5);
        rd("t5_count_kept", 9'h182, 9'd7);
        rd("t5_ctrl_kept", 9'h181, 9'd0);
        wr(9'h181, 9'h1FC);
        rd("t5_ctrl_upper", 9'h181, 9'd0);

        // 6: reset while running with COUNT=2
        wr(9'h180, 9'd3);
        tick_log.delete();
        p = cyc;
        wr(9'h181, 9'd1);
        wait_until("t6_sched", p + 5);
        rd("t6_count_pre", 9'h182, 9'd2);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        rd("t6_count", 9'h182, 9'd0);
        rd("t6_ctrl",  9'h181, 9'd0);
        rd("t6_load",  9'h180, 9'd0);
        rd("t6_status", 9'h183, 9'd0);
        chk("t6_expired", Expired, 0);
        repeat (40) step();
        chk("t6_no_tick", tick_log.size(), 0);

        repeat (2) step();
        chk("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
